reversible_alu_pipe: RTL and testbench

//  Parametrised, pipelined successor of the combinational reversible ALU. Adds a 3-bit opcode

---
 rtl/reversible_alu_pkg.sv | 19 +
 rtl/reversible_alu_core.sv | 64 ++++++
 rtl/reversible_alu_pipe.sv | 141 ++++++++++++++
 tb/tb_reversible_alu_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reversible_alu_pkg.sv
// Shared definitions for the pipelined reversible ALU.
//   OP_W : opcode width
//   op_e : opcode encoding (all eight codes are legal)
package reversible_alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OpFredkin = 3'd0,
    OpPeres   = 3'd1,
    OpAdd     = 3'd2,
    OpAdd1    = 3'd3,
    OpSub     = 3'd4,
    OpXor     = 3'd5,
    OpAnd     = 3'd6,
    OpOr      = 3'd7
  } op_e;

endpackage

// File: rtl/reversible_alu_core.sv
// Combinational compute core of the reversible ALU.
// Ports:
//   i_op     : opcode
//   i_a      : operand A (control input of the Fredkin/Peres gates)
//   i_b      : operand B
//   i_c      : operand C (gate ops only)
//   o_result : primary result
//   o_aux    : secondary gate output, 0 for non-gate ops
//   o_carry  : carry-out of ADD/ADD1/SUB, 0 otherwise
//   o_zero   : o_result == 0
module reversible_alu_core
  import reversible_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_aux,
  output logic             o_carry,
  output logic             o_zero
);

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;

  // One adder serves ADD, ADD1 and SUB: SUB is A + ~B + 1, so carry=1 means no borrow.
  always_comb begin
    w_b_eff = (i_op == OpSub) ? ~i_b : i_b;
    w_cin   = (i_op == OpAdd1) || (i_op == OpSub);
    w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
  end

  always_comb begin
    o_result = '0;
    o_aux    = '0;
    o_carry  = 1'b0;
    unique case (i_op)
      OpFredkin: begin
        // Controlled swap: A=1 routes C to result and B to aux.
        o_result = (~i_a & i_b) | (i_a & i_c);
        o_aux    = (~i_a & i_c) | (i_a & i_b);
      end
      OpPeres: begin
        o_result = (i_a & i_b) ^ i_c;
        o_aux    = i_a ^ i_b;
      end
      OpAdd, OpAdd1, OpSub: begin
        o_result = w_sum[WIDTH-1:0];
        o_carry  = w_sum[WIDTH];
      end
      OpXor: o_result = i_a ^ i_b;
      OpAnd: o_result = i_a & i_b;
      OpOr:  o_result = i_a | i_b;
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/reversible_alu_pipe.sv
// Two-stage pipelined reversible ALU with valid/ready flow control.
// Stage 1 captures opcode and operands; stage 2 captures computed outputs.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake
//   in_op, in_a/b/c      : opcode and operands
//   out_valid/out_ready  : result handshake
//   out_op               : opcode echoed with the result
//   out_result, out_aux  : primary and secondary results
//   out_carry, out_zero  : flags
//   op_count             : saturating count of delivered results
module reversible_alu_pipe
  import reversible_alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [WIDTH-1:0]   in_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    out_op,
  output logic [WIDTH-1:0]   out_result,
  output logic [WIDTH-1:0]   out_aux,
  output logic               out_carry,
  output logic               out_zero,
  output logic [COUNT_W-1:0] op_count
);

  // Stage 1: captured request
  logic             r_s1_valid;
  op_e              r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [WIDTH-1:0] r_s1_c;

  // Stage 2: computed response
  logic             r_s2_valid;
  op_e              r_s2_op;
  logic [WIDTH-1:0] r_s2_result;
  logic [WIDTH-1:0] r_s2_aux;
  logic             r_s2_carry;
  logic             r_s2_zero;

  logic [COUNT_W-1:0] r_count;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_accept;
  logic             w_deliver;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_aux;
  logic             w_carry;
  logic             w_zero;

  // A stage advances when it is empty or the stage after it is moving.
  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign w_accept  = in_valid && w_s1_adv;
  assign w_deliver = r_s2_valid && out_ready;

  reversible_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_op    (r_s1_op),
    .i_a     (r_s1_a),
    .i_b     (r_s1_b),
    .i_c     (r_s1_c),
    .o_result(w_result),
    .o_aux   (w_aux),
    .o_carry (w_carry),
    .o_zero  (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OpFredkin;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_c     <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
      end
      if (w_accept) begin
        r_s1_op <= op_e'(in_op);
        r_s1_a  <= in_a;
        r_s1_b  <= in_b;
        r_s1_c  <= in_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_op     <= OpFredkin;
      r_s2_result <= '0;
      r_s2_aux    <= '0;
      r_s2_carry  <= 1'b0;
      r_s2_zero   <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      // Data only moves with a valid op, so a stalled output stays frozen.
      if (w_s2_adv && r_s1_valid) begin
        r_s2_op     <= r_s1_op;
        r_s2_result <= w_result;
        r_s2_aux    <= w_aux;
        r_s2_carry  <= w_carry;
        r_s2_zero   <= w_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_deliver && (r_count != '1)) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_op     = r_s2_op;
  assign out_result = r_s2_result;
  assign out_aux    = r_s2_aux;
  assign out_carry  = r_s2_carry;
  assign out_zero   = r_s2_zero;
  assign op_count   = r_count;

endmodule

// File: tb/tb_reversible_alu_pipe.sv
// Scoreboard bench for reversible_alu_pipe: the driver pushes hand-computed expectations,
// a monitor pops and compares on every delivered result.
module tb_reversible_alu_pipe;
  import reversible_alu_pkg::*;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = 3'd0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [W-1:0]  in_c = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2:0]    out_op;
  logic [W-1:0]  out_result;
  logic [W-1:0]  out_aux;
  logic          out_carry;
  logic          out_zero;
  logic [15:0]   op_count;

  // Second instance with a narrow counter to exercise saturation
  logic          in_valid4 = 1'b0;
  logic          in_ready4;
  logic [2:0]    in_op4 = 3'd2;
  logic [W-1:0]  in_a4 = 32'd1;
  logic [W-1:0]  in_b4 = 32'd1;
  logic [W-1:0]  in_c4 = 32'd0;
  logic          out_valid4;
  logic [2:0]    out_op4;
  logic [W-1:0]  out_result4;
  logic [W-1:0]  out_aux4;
  logic          out_carry4;
  logic          out_zero4;
  logic [3:0]    op_count4;

  reversible_alu_pipe #(.WIDTH(W), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_result(out_result), .out_aux(out_aux), .out_carry(out_carry),
    .out_zero(out_zero), .op_count(op_count)
  );

  reversible_alu_pipe #(.WIDTH(W), .COUNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .in_op(in_op4),
    .in_a(in_a4), .in_b(in_b4), .in_c(in_c4), .out_valid(out_valid4), .out_ready(1'b1),
    .out_op(out_op4), .out_result(out_result4), .out_aux(out_aux4), .out_carry(out_carry4),
    .out_zero(out_zero4), .op_count(op_count4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] res;
    logic [W-1:0] aux;
    logic         carry;
    logic         zero;
    int           acc_cyc;
    bit           chk_lat;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int n_deliv = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Drive one op and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] res, input logic [W-1:0] aux,
                      input logic carry, input logic zero, input bit chk_lat);
    exp_t e;
    bit   acc = 1'b0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_c = c;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        e.op = op; e.res = res; e.aux = aux; e.carry = carry; e.zero = zero;
        e.acc_cyc = cyc; e.chk_lat = chk_lat;
        q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout op=%0d in_ready stuck low", op);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      exp_t e;
      n_deliv++;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got op=%0d res=%h (no result expected)", out_op,
                 out_result);
      end else begin
        e = q.pop_front();
        if (out_op !== e.op || out_result !== e.res || out_aux !== e.aux ||
            out_carry !== e.carry || out_zero !== e.zero) begin
          failures++;
          $display("FAIL result op=%0d got res=%h aux=%h c=%b z=%b op=%0d want res=%h aux=%h c=%b z=%b",
                   e.op, out_result, out_aux, out_carry, out_zero, out_op, e.res, e.aux,
                   e.carry, e.zero);
        end
        if (e.chk_lat) begin
          checks++;
          if (cyc - e.acc_cyc != 2) begin
            failures++;
            $display("FAIL latency op=%0d got=%0d want=2", e.op, cyc - e.acc_cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] snap_main;
    logic [63:0] snap_aux;
    int          d0;
    int          acc4;
    bit          seen4;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_op_count", 64'(op_count), 64'd0);
    @(posedge clk);
    #1;

    // Directed single ops, issued back to back with the sink always ready
    send(OpAdd1,    32'hFFFFFFFF, 32'h00000000, 32'h0, 32'h00000000, 32'h0, 1'b1, 1'b1, 1'b1);
    send(OpPeres,   32'h12345678, 32'h9ABCDEF0, 32'h87654321, 32'h95511551, 32'h88888888,
         1'b0, 1'b0, 1'b1);
    send(OpFredkin, 32'hAAAAAAAA, 32'h55555555, 32'h0, 32'h55555555, 32'h0, 1'b0, 1'b0, 1'b1);
    send(OpFredkin, 32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0, 32'h9ABC5678, 32'h1234DEF0,
         1'b0, 1'b0, 1'b1);
    send(OpSub,     32'h00000000, 32'h00000001, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1);
    send(OpSub,     32'h0000000A, 32'h0000000A, 32'h0, 32'h00000000, 32'h0, 1'b1, 1'b1, 1'b1);
    send(OpXor,     32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h00000000, 32'h0, 1'b0, 1'b1, 1'b1);
    send(OpAnd,     32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1);
    send(OpOr,      32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1);
    send(OpAdd,     32'h7FFFFFFF, 32'h00000001, 32'h0, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    drain();
    chk("op_count_after_singles", 64'(op_count), 64'd10);

    // Four back-to-back ops with a three-cycle sink stall mid-stream
    fork
      begin
        send(OpAdd, 32'h00000001, 32'h00000002, 32'h0, 32'h00000003, 32'h0, 1'b0, 1'b0, 1'b0);
        send(OpSub, 32'h00000005, 32'h00000003, 32'h0, 32'h00000002, 32'h0, 1'b1, 1'b0, 1'b0);
        send(OpAdd, 32'h80000000, 32'h80000000, 32'h0, 32'h00000000, 32'h0, 1'b1, 1'b1, 1'b0);
        send(OpAnd, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h0, 32'h30303030, 32'h0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        bit seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge clk);
          if (out_valid && out_ready) seen = 1'b1;
        end
        if (!seen) begin
          checks++;
          failures++;
          $display("FAIL stall_first_result got=none want=delivery");
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        snap_main = 64'({out_op, out_carry, out_zero, out_result});
        snap_aux  = 64'(out_aux);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_in_ready_full", 64'(in_ready), 64'd0);
        repeat (2) begin
          @(negedge clk);
          chk("stall_frozen_main", 64'({out_op, out_carry, out_zero, out_result}), snap_main);
          chk("stall_frozen_aux", 64'(out_aux), snap_aux);
          chk("stall_in_ready_full", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("op_count_after_stall", 64'(op_count), 64'd14);

    // Reset with two ops in flight
    send(OpAdd, 32'h00000001, 32'h00000001, 32'h0, 32'h00000002, 32'h0, 1'b0, 1'b0, 1'b0);
    send(OpOr,  32'h0000F000, 32'h0000000F, 32'h0, 32'h0000F00F, 32'h0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("inflight_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_op_count", 64'(op_count), 64'd0);
    q.delete();
    d0 = n_deliv;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postreset_in_ready", 64'(in_ready), 64'd1);
    repeat (5) @(negedge clk);
    chk("postreset_none_delivered", 64'(n_deliv), 64'(d0));
    chk("postreset_op_count", 64'(op_count), 64'd0);

    // Saturation of a 4-bit counter over 20 ops
    @(posedge clk);
    #1;
    in_valid4 = 1'b1;
    acc4 = 0;
    seen4 = 1'b0;
    for (int t = 0; t < 100 && acc4 < 20; t++) begin
      @(negedge clk);
      if (in_ready4) acc4++;
      if (out_valid4 && !seen4) begin
        seen4 = 1'b1;
        chk("cnt4_first_result", 64'({out_op4, out_carry4, out_zero4, out_result4}),
            64'({3'd2, 1'b0, 1'b0, 32'd2}));
        chk("cnt4_first_aux", 64'(out_aux4), 64'd0);
      end
      @(posedge clk);
      #1;
      if (acc4 == 20) in_valid4 = 1'b0;
    end
    chk("cnt4_accepted", 64'(acc4), 64'd20);
    repeat (5) @(posedge clk);
    #1;
    chk("cnt4_saturated", 64'(op_count4), 64'hF);

    chk("final_queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
